boton_event_scheduler: RTL and testbench
========================================

// Module: boton_event_scheduler
// PURPOSE
//   Collects event requests from the button conditioning blocks (reset long-press, action, select, test)
//   and serialises them into one command stream for the pet control FSM over a valid/ready handshake.
//   req[0] is the urgent class (reset long-press) with fixed top priority; req[1..N_REQ-1] share
//   round-robin. A post-command cooldown throttles the stream, and repeated events on a pending line are counted as drops.
// PARAMETERS
//   N_REQ     4   number of requester lines (>=2); index 0 = urgent
//   COOLDOWN  5   idle cycles enforced after each accepted command (0 = none)
//   IDW       $clog2(N_REQ)  width of cmd_id (derived, do not override)
// PORTS
//   clk        in   1      system clock, all logic on rising edge
//   rst        in   1      synchronous, active-high reset
//   req        in   N_REQ  level outputs of button blocks; 0->1 edge = one event
//   cmd_valid  out  1      command available
//   cmd_ready  in   1      consumer accepts when cmd_valid & cmd_ready on an edge
//   cmd_id     out  IDW    index of requester being served; stable while cmd_valid
//   busy       out  1      state != IDLE
//   pending    out  N_REQ  registered pending-event bits
//   drop_cnt   out  8      saturating count of events lost to an already-pending line
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, cmd_valid=0, cmd_id=0, pending=0, drop_cnt=0, rr_ptr=N_REQ-1,
//     cd_cnt=0, req_q=all ones (a line held high through reset gives no event until it falls and rises).
//     rst mid-ISSUE/COOLDOWN aborts: cmd_valid low right after that edge; no command is replayed.
//   Edge detect: ev = req & ~req_q; req_q <= req every cycle.
//   Pending: ev[i] & ~pending[i] -> pending[i] set. ev[i] & pending[i] (not cleared same edge) -> dropped,
//     drop_cnt+1, saturating at 255. If the grant clears pending[i] on the same edge that ev[i]=1,
//     the bit stays set (new event kept, no drop).
//   FSM:
//     IDLE: if pending!=0: grant g = 0 if pending[0], else first set bit among 1..N_REQ-1
//           searching upward from rr_ptr+1 with wrap (index 0 skipped). cmd_id<=g, pending[g]<=0,
//           rr_ptr<=g when g!=0, cmd_valid<=1, -> ISSUE.
//     ISSUE: hold cmd_valid=1 and cmd_id. On cmd_valid&cmd_ready: cmd_valid<=0;
//           COOLDOWN==0 or pending[0]=1 -> IDLE; else cd_cnt<=COOLDOWN-1 -> COOLDOWN. No preemption in ISSUE.
//     COOLDOWN: cd_cnt decrements; at 0 -> IDLE. If pending[0] set -> IDLE immediately.
//   Latency: req rising, sampled at edge k -> pending at k -> cmd_valid high after edge k+1 when IDLE.
//   Back-to-back with ready=1, COOLDOWN=C: successive cmd_valid pulses are C+2 cycles apart.
//   busy=1 in ISSUE and COOLDOWN. cmd_valid registered; cmd_id output held after accept.
// TESTING (N_REQ=4, COOLDOWN=5)
//   1 rst=1 for 2 cycles, req=4'b0110 held -> cmd_valid=0, busy=0, pending=0, drop_cnt=0; no cmd
//     after release until req lines fall and rise again.
//   2 req[2] 1-cycle pulse, cmd_ready=1 -> cmd_valid 1 cycle, 2 edges after sample, cmd_id=2;
//     busy=1 for 6 cycles, then 0.
//   3 req=4'b1110 same cycle, ready=1 -> cmd_id 1,2,3 at 7-cycle spacing; then req[1] & req[3]
//     together -> order 1 then 3.
//   4 cmd_id=3 valid, ready=0 for 4 cycles, req[0] pulsed meanwhile -> cmd_id stays 3 until accept;
//     cooldown skipped, cmd_id=0 valid next cycle after IDLE.
//   5 cmd_id=2 stalled (ready=0); req[1] pulsed 3 times -> pending[1]=1, drop_cnt=2; then 300 more
//     pulses -> drop_cnt=255 (saturated).
//   6 rst=1 for 1 cycle while ISSUE, cmd_id=1 -> cmd_valid=0, pending=0, state IDLE next cycle.

Source files
------------

// File: rtl/boton_event_scheduler.sv
// ---------------------------------------------------------------------------
// boton_event_scheduler
//   Turns the level outputs of the button conditioning blocks into a single
//   serialised command stream for the pet control FSM.
//   - req[0] (reset long-press) is urgent and always wins arbitration.
//   - req[1..N_REQ-1] are served round-robin.
//   - After every accepted command a cooldown of COOLDOWN idle cycles is
//     enforced, except when an urgent event is waiting.
//   - A new event on a line that already has one pending is counted as a drop.
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   req        : request levels, a 0->1 edge is one event
//   cmd_valid  : command available (registered)
//   cmd_ready  : consumer accepts on cmd_valid & cmd_ready
//   cmd_id     : index of the requester being served, held after accept
//   busy       : FSM is in ISSUE or COOLDOWN
//   pending    : registered pending-event bits
//   drop_cnt   : saturating count of events lost to an already-pending line
// ---------------------------------------------------------------------------
module boton_event_scheduler #(
  parameter int N_REQ    = 4,
  parameter int COOLDOWN = 5,
  parameter int IDW      = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [IDW-1:0]   cmd_id,
  output logic             busy,
  output logic [N_REQ-1:0] pending,
  output logic [7:0]       drop_cnt
);

  // Wide enough to hold COOLDOWN-1 and never zero width when COOLDOWN is 0.
  localparam int CDW = $clog2(COOLDOWN + 2);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  state_t           state_r;
  logic [N_REQ-1:0] req_q_r;
  logic [IDW-1:0]   rr_ptr_r;
  logic [CDW-1:0]   cd_cnt_r;

  logic [N_REQ-1:0] ev_s;
  logic [N_REQ-1:0] clr_s;
  logic [N_REQ-1:0] drop_s;
  logic [N_REQ-1:0] pending_nxt_s;
  logic [IDW-1:0]   grant_s;
  logic             grant_en_s;
  logic [7:0]       drop_nxt_s;

  // First set bit among lines 1..N_REQ-1, searching upward from ptr+1 and
  // wrapping back to line 1 (line 0 never takes part in round-robin).
  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] p,
                                             input logic [IDW-1:0]   ptr);
    logic [IDW-1:0] pick;
    logic [IDW-1:0] idx;
    logic           found;
    pick  = {IDW{1'b0}};
    found = 1'b0;
    for (int k = 1; k < N_REQ; k++) begin
      idx = IDW'(((int'(ptr) - 1 + k) % (N_REQ - 1)) + 1);
      if (!found && p[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Add the number of dropped events to the counter, clamping at 255.
  function automatic logic [7:0] sat_add(input logic [7:0]       cnt,
                                         input logic [N_REQ-1:0] d);
    int sum;
    sum = int'(cnt);
    for (int i = 0; i < N_REQ; i++) begin
      sum = sum + int'(d[i]);
    end
    return (sum > 255) ? 8'd255 : 8'(sum);
  endfunction

  // Edge detection, arbitration and next pending/drop values.
  always_comb begin
    ev_s       = req & ~req_q_r;
    grant_en_s = 1'b0;
    clr_s      = {N_REQ{1'b0}};
    if (pending[0]) begin
      grant_s = {IDW{1'b0}};
    end else begin
      grant_s = rr_pick(pending, rr_ptr_r);
    end
    if ((state_r == ST_IDLE) && (pending != {N_REQ{1'b0}})) begin
      grant_en_s     = 1'b1;
      clr_s[grant_s] = 1'b1;
    end else begin
      grant_en_s = 1'b0;
    end
    // An event landing on the edge that clears its own line is kept, not dropped.
    drop_s        = ev_s & pending & ~clr_s;
    pending_nxt_s = (pending & ~clr_s) | ev_s;
    drop_nxt_s    = sat_add(drop_cnt, drop_s);
  end

  // Scheduler FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cmd_valid <= 1'b0;
      cmd_id    <= {IDW{1'b0}};
      busy      <= 1'b0;
      pending   <= {N_REQ{1'b0}};
      drop_cnt  <= 8'd0;
      rr_ptr_r  <= IDW'(N_REQ - 1);
      cd_cnt_r  <= {CDW{1'b0}};
      // All ones so a line held high through reset is not seen as a new event.
      req_q_r   <= {N_REQ{1'b1}};
    end else begin
      req_q_r  <= req;
      pending  <= pending_nxt_s;
      drop_cnt <= drop_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (grant_en_s) begin
            cmd_id    <= grant_s;
            cmd_valid <= 1'b1;
            busy      <= 1'b1;
            state_r   <= ST_ISSUE;
            if (grant_s != {IDW{1'b0}}) begin
              rr_ptr_r <= grant_s;
            end
          end
        end
        ST_ISSUE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            // An urgent event skips the cooldown.
            if ((COOLDOWN == 0) || pending[0]) begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
            end else begin
              cd_cnt_r <= CDW'(COOLDOWN - 1);
              state_r  <= ST_COOLDOWN;
            end
          end
        end
        ST_COOLDOWN: begin
          if (pending[0] || (cd_cnt_r == {CDW{1'b0}})) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            cd_cnt_r <= cd_cnt_r - CDW'(1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cmd_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boton_event_scheduler.sv
// ---------------------------------------------------------------------------
// tb_boton_event_scheduler
//   Directed bench for boton_event_scheduler with N_REQ=4, COOLDOWN=5.
//   Inputs change 1 time unit after a rising edge; outputs are checked at the
//   same point, i.e. they reflect the registers updated by that edge.
// ---------------------------------------------------------------------------
module tb_boton_event_scheduler;

  localparam int N_REQ    = 4;
  localparam int COOLDOWN = 5;
  localparam int IDW      = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_REQ-1:0] req;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [IDW-1:0]   cmd_id;
  logic             busy;
  logic [N_REQ-1:0] pending;
  logic [7:0]       drop_cnt;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;
  int n;
  int busy_cycles;

  always #5 clk = ~clk;

  boton_event_scheduler #(.N_REQ(N_REQ), .COOLDOWN(COOLDOWN)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_id   (cmd_id),
    .busy     (busy),
    .pending  (pending),
    .drop_cnt (drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks until cmd_valid is high (bounded); n = ticks taken.
  task automatic wait_valid(input string tag, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while ((cmd_valid !== 1'b1) && (cnt < 40));
    chk({tag, "_valid_seen"}, 32'(cmd_valid), 32'd1);
  endtask

  // Ticks until busy is low (bounded).
  task automatic wait_idle(input string tag);
    int cnt;
    cnt = 0;
    while ((busy !== 1'b0) && (cnt < 40)) begin
      tick();
      cnt++;
    end
    chk({tag, "_idle_seen"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // 1: reset with lines held high; held lines give no event afterwards
    rst = 1'b1; req = 4'b0110; cmd_ready = 1'b0;
    tick(); tick();
    chk("rst_valid",   32'(cmd_valid), 32'd0);
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_pending", 32'(pending),   32'd0);
    chk("rst_drop",    32'(drop_cnt),  32'd0);
    chk("rst_id",      32'(cmd_id),    32'd0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("held_pending", 32'(pending),   32'd0);
    chk("held_valid",   32'(cmd_valid), 32'd0);
    req = 4'b0000;
    tick();

    // 2: single pulse on req[2], latency and busy duration
    req = 4'b0100; cmd_ready = 1'b1;
    tick();
    req = 4'b0000;
    chk("t2_pending", 32'(pending),   32'h4);
    chk("t2_nvalid",  32'(cmd_valid), 32'd0);
    tick();
    chk("t2_valid",   32'(cmd_valid), 32'd1);
    chk("t2_id",      32'(cmd_id),    32'd2);
    chk("t2_clr",     32'(pending),   32'd0);
    busy_cycles = 1;
    tick();
    chk("t2_acc_valid", 32'(cmd_valid), 32'd0);
    chk("t2_id_held",   32'(cmd_id),    32'd2);
    for (int i = 0; i < 8; i++) begin
      if (busy) busy_cycles++;
      tick();
    end
    chk("t2_busy_cycles", 32'(busy_cycles), 32'd6);
    chk("t2_busy_end",    32'(busy),        32'd0);

    // 3: three simultaneous lines from a fresh round-robin pointer
    rst = 1'b1; tick(); rst = 1'b0; tick();
    req = 4'b1110;
    tick();
    req = 4'b0000;
    wait_valid("t3a", n);
    chk("t3a_lat", 32'(n), 32'd1);
    chk("t3a_id",  32'(cmd_id), 32'd1);
    wait_valid("t3b", n);
    chk("t3b_gap", 32'(n), 32'd7);
    chk("t3b_id",  32'(cmd_id), 32'd2);
    wait_valid("t3c", n);
    chk("t3c_gap", 32'(n), 32'd7);
    chk("t3c_id",  32'(cmd_id), 32'd3);
    tick();
    wait_idle("t3c");
    req = 4'b1010;
    tick();
    req = 4'b0000;
    wait_valid("t3d", n);
    chk("t3d_id",  32'(cmd_id), 32'd1);
    wait_valid("t3e", n);
    chk("t3e_gap", 32'(n), 32'd7);
    chk("t3e_id",  32'(cmd_id), 32'd3);
    tick();
    wait_idle("t3e");

    // 4: stalled cmd 3, urgent event arrives, cooldown skipped
    cmd_ready = 1'b0;
    req = 4'b1000; tick();
    req = 4'b0000; tick();
    chk("t4_valid", 32'(cmd_valid), 32'd1);
    chk("t4_id",    32'(cmd_id),    32'd3);
    req = 4'b0001; tick();
    req = 4'b0000;
    chk("t4_pend0", 32'(pending), 32'h1);
    tick(); tick(); tick();
    chk("t4_hold_valid", 32'(cmd_valid), 32'd1);
    chk("t4_hold_id",    32'(cmd_id),    32'd3);
    cmd_ready = 1'b1;
    tick();
    chk("t4_acc_valid", 32'(cmd_valid), 32'd0);
    chk("t4_no_cd",     32'(busy),      32'd0);
    tick();
    chk("t4_urg_valid", 32'(cmd_valid), 32'd1);
    chk("t4_urg_id",    32'(cmd_id),    32'd0);
    tick();
    wait_idle("t4");

    // 5: drops on an already-pending line, then saturation
    cmd_ready = 1'b0;
    req = 4'b0100; tick();
    req = 4'b0000; tick();
    chk("t5_id", 32'(cmd_id), 32'd2);
    for (int i = 0; i < 3; i++) begin
      req = 4'b0010; tick();
      req = 4'b0000; tick();
    end
    chk("t5_pending", 32'(pending),  32'h2);
    chk("t5_drop2",   32'(drop_cnt), 32'd2);
    for (int i = 0; i < 300; i++) begin
      req = 4'b0010; tick();
      req = 4'b0000; tick();
    end
    chk("t5_drop_sat", 32'(drop_cnt), 32'd255);
    chk("t5_still_id", 32'(cmd_id),   32'd2);

    // 6: reset while issuing cmd 1 aborts everything
    cmd_ready = 1'b1; tick();
    cmd_ready = 1'b0;
    wait_valid("t6", n);
    chk("t6_id", 32'(cmd_id), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_valid",   32'(cmd_valid), 32'd0);
    chk("t6_pending", 32'(pending),   32'd0);
    chk("t6_busy",    32'(busy),      32'd0);
    chk("t6_drop",    32'(drop_cnt),  32'd0);
    tick();
    chk("t6_no_replay", 32'(cmd_valid), 32'd0);

    // 7: urgent event cuts a running cooldown short
    cmd_ready = 1'b1;
    req = 4'b0100; tick();
    req = 4'b0000;
    wait_valid("t7", n);
    chk("t7_id", 32'(cmd_id), 32'd2);
    tick();
    req = 4'b0001; tick();
    req = 4'b0000;
    chk("t7_cd_busy", 32'(busy), 32'd1);
    tick();
    chk("t7_cd_cut", 32'(busy), 32'd0);
    tick();
    chk("t7_urg_valid", 32'(cmd_valid), 32'd1);
    chk("t7_urg_id",    32'(cmd_id),    32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
